// File: rtl/hnf_entry_rr_sched_pkg.sv
// Shared HNF parameters and helpers.
// Entry count defaults and one-hot encode.
package hnf_entry_rr_sched_pkg;

  localparam int HNF_ENTRIES_NUM   = 32;
  localparam int HNF_ENTRIES_WIDTH = 5;
  localparam int HNF_OH_MAX        = 64;

  function automatic logic [31:0] hnf_oh2bin(
    input logic [HNF_OH_MAX-1:0] oh
  );
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < HNF_OH_MAX; i++) begin
      if (oh[i]) b = b | 32'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/hnf_sel_bit_from_vec.sv
// Round-robin bit pick: lowest set bit at or
// above a one-hot start, else lowest overall.
module hnf_sel_bit_from_vec #(
  parameter int N = 32
) (
  input  logic [N-1:0] vec,
  input  logic [N-1:0] start,
  output logic [N-1:0] sel,
  output logic         found
);

  logic [N-1:0] above;
  logic [N-1:0] hi_lo;
  logic [N-1:0] all_lo;

  // mask off bits below start, isolate lowest
  always_comb begin
    above  = vec & ~(start - N'(1));
    hi_lo  = above & (~above + N'(1));
    all_lo = vec & (~vec + N'(1));
    sel    = (|above) ? hi_lo : all_lo;
    found  = |vec;
  end

endmodule

// File: rtl/hnf_entry_rr_sched.sv
// Round-robin entry scheduler with a held
// output register and per-entry pending mask.
module hnf_entry_rr_sched
  import hnf_entry_rr_sched_pkg::*;
#(
  parameter int ENTRIES_NUM   = HNF_ENTRIES_NUM,
  parameter int ENTRIES_WIDTH = HNF_ENTRIES_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ENTRIES_NUM-1:0]   entry_vec,
  input  logic [ENTRIES_NUM-1:0]   entry_done_vec,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [ENTRIES_NUM-1:0]   out_entry_ptr,
  output logic [ENTRIES_WIDTH-1:0] out_entry_idx,
  output logic [ENTRIES_NUM-1:0]   pend_vec
);

  logic                   out_valid_q;
  logic                   out_valid_d;
  logic [ENTRIES_NUM-1:0] out_entry_ptr_q;
  logic [ENTRIES_NUM-1:0] out_entry_ptr_d;
  logic [ENTRIES_NUM-1:0] start_ptr_q;
  logic [ENTRIES_NUM-1:0] start_ptr_d;
  logic [ENTRIES_NUM-1:0] pend_mask_q;
  logic [ENTRIES_NUM-1:0] pend_mask_d;

  logic                   hs;
  logic [ENTRIES_NUM-1:0] hs_grant;
  logic [ENTRIES_NUM-1:0] eligible;
  logic [ENTRIES_NUM-1:0] start_nxt;
  logic [ENTRIES_NUM-1:0] sel;
  logic                   found;

  // handshake, eligibility and next start
  always_comb begin
    hs        = out_valid_q & out_ready;
    hs_grant  = hs ? out_entry_ptr_q : '0;
    eligible  = entry_vec & ~pend_mask_q
              & ~hs_grant;
    start_nxt = hs ? {out_entry_ptr_q[ENTRIES_NUM-2:0],
                      out_entry_ptr_q[ENTRIES_NUM-1]}
                   : start_ptr_q;
  end

  hnf_sel_bit_from_vec #(
    .N(ENTRIES_NUM)
  ) u_sel (
    .vec  (eligible),
    .start(start_nxt),
    .sel  (sel),
    .found(found)
  );

  // output reload, pointer advance, pend set-wins
  always_comb begin
    out_valid_d     = out_valid_q;
    out_entry_ptr_d = out_entry_ptr_q;
    if (!out_valid_q || hs) begin
      out_valid_d     = found;
      out_entry_ptr_d = found ? sel : '0;
    end
    start_ptr_d = start_nxt;
    pend_mask_d = (pend_mask_q & ~entry_done_vec)
                | hs_grant;
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q     <= 1'b0;
      out_entry_ptr_q <= '0;
      start_ptr_q     <= ENTRIES_NUM'(1);
      pend_mask_q     <= '0;
    end else begin
      out_valid_q     <= out_valid_d;
      out_entry_ptr_q <= out_entry_ptr_d;
      start_ptr_q     <= start_ptr_d;
      pend_mask_q     <= pend_mask_d;
    end
  end

  // outputs
  always_comb begin
    out_valid     = out_valid_q;
    out_entry_ptr = out_entry_ptr_q;
    out_entry_idx = ENTRIES_WIDTH'(
      hnf_oh2bin(HNF_OH_MAX'(out_entry_ptr_q)));
    pend_vec      = pend_mask_q;
  end

endmodule

// File: tb/tb_hnf_entry_rr_sched.sv
// Self-checking bench for hnf_entry_rr_sched:
// per-cycle vector table plus grant scoreboard.
module tb_hnf_entry_rr_sched;

  logic        clk;
  logic        rst;
  logic [31:0] entry_vec;
  logic [31:0] entry_done_vec;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_entry_ptr;
  logic [4:0]  out_entry_idx;
  logic [31:0] pend_vec;

  int n_chk;
  int n_fail;

  hnf_entry_rr_sched #(
    .ENTRIES_NUM  (32),
    .ENTRIES_WIDTH(5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .entry_vec     (entry_vec),
    .entry_done_vec(entry_done_vec),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_entry_ptr (out_entry_ptr),
    .out_entry_idx (out_entry_idx),
    .pend_vec      (pend_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ev;
    logic        rdy;
    logic [31:0] dn;
    logic        v;
    int          idx;
    logic [31:0] pend;
  } vec_t;

  vec_t tbl[14];
  int   sb[$];
  int   cnt[32];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm,
                         input logic v,
                         input int idx);
    logic [31:0] p;
    p = v ? (32'h1 << idx) : 32'h0;
    chk({nm, "_valid"}, 32'(out_valid), 32'(v));
    chk({nm, "_idx"}, 32'(out_entry_idx),
        v ? 32'(idx) : 32'h0);
    chk({nm, "_ptr"}, out_entry_ptr, p);
  endtask

  initial begin
    int exp_i;
    int iters;
    logic [31:0] g;
    n_chk  = 0;
    n_fail = 0;
    foreach (cnt[i]) cnt[i] = 0;

    tbl[0]  = '{32'h9, 1'b1, 32'h0, 1'b1, 0, 32'h0};
    tbl[1]  = '{32'h9, 1'b1, 32'h0, 1'b1, 3, 32'h1};
    tbl[2]  = '{32'h9, 1'b1, 32'h0, 1'b0, 0, 32'h9};
    tbl[3]  = '{32'h0, 1'b1, 32'h9, 1'b0, 0, 32'h0};
    tbl[4]  = '{32'h20, 1'b0, 32'h0, 1'b1, 5, 32'h0};
    tbl[5]  = '{32'h20, 1'b1, 32'h0, 1'b0, 0, 32'h20};
    tbl[6]  = '{32'h20, 1'b1, 32'h0, 1'b0, 0, 32'h20};
    tbl[7]  = '{32'h20, 1'b1, 32'h0, 1'b0, 0, 32'h20};
    tbl[8]  = '{32'h20, 1'b1, 32'h20, 1'b0, 0, 32'h0};
    tbl[9]  = '{32'h20, 1'b0, 32'h0, 1'b1, 5, 32'h0};
    tbl[10] = '{32'h80, 1'b1, 32'h0, 1'b1, 7, 32'h20};
    tbl[11] = '{32'h0, 1'b1, 32'ha0, 1'b0, 0, 32'h80};
    tbl[12] = '{32'h0, 1'b0, 32'h80, 1'b0, 0, 32'h0};
    tbl[13] = '{32'h0, 1'b0, 32'hffff_ffff,
                1'b0, 0, 32'h0};

    rst            = 1'b1;
    entry_vec      = '0;
    entry_done_vec = '0;
    out_ready      = 1'b0;
    tick();
    tick();
    chk_out("reset", 1'b0, 0);
    chk("reset_pend", pend_vec, 32'h0);
    chk("reset_start", dut.start_ptr_q, 32'h1);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      entry_vec      = tbl[i].ev;
      out_ready      = tbl[i].rdy;
      entry_done_vec = tbl[i].dn;
      tick();
      chk_out($sformatf("row%0d", i),
              tbl[i].v, tbl[i].idx);
      chk($sformatf("row%0d_pend", i),
          pend_vec, tbl[i].pend);
      if (i == 2)
        chk("row2_start", dut.start_ptr_q,
            32'h10);
    end
    entry_done_vec = '0;

    entry_vec = 32'h4;
    out_ready = 1'b0;
    tick();
    chk_out("hold_first", 1'b1, 2);
    for (int i = 0; i < 5; i++) begin
      if (i >= 3) entry_vec = '0;
      tick();
      chk_out($sformatf("hold%0d", i), 1'b1, 2);
    end
    out_ready = 1'b1;
    tick();
    chk("hold_pend", pend_vec, 32'h4);
    chk_out("hold_after", 1'b0, 0);
    out_ready      = 1'b0;
    entry_done_vec = 32'h4;
    tick();
    entry_done_vec = '0;

    entry_vec = 32'h4000_0000;
    tick();
    chk_out("wrap_e30", 1'b1, 30);
    out_ready = 1'b1;
    tick();
    chk("wrap_start31", dut.start_ptr_q,
        32'h8000_0000);
    out_ready      = 1'b0;
    entry_vec      = '0;
    entry_done_vec = 32'h4000_0000;
    tick();
    entry_done_vec = '0;
    entry_vec      = 32'h8000_0002;
    tick();
    chk_out("wrap_g31", 1'b1, 31);
    out_ready = 1'b1;
    tick();
    chk_out("wrap_g1", 1'b1, 1);
    chk("wrap_start0", dut.start_ptr_q, 32'h1);
    tick();
    chk_out("wrap_idle", 1'b0, 0);
    chk("wrap_start2", dut.start_ptr_q, 32'h4);
    entry_vec      = '0;
    out_ready      = 1'b0;
    entry_done_vec = 32'hffff_ffff;
    tick();
    entry_done_vec = '0;

    entry_vec = 32'hffff_ffff;
    out_ready = 1'b1;
    tick();
    chk_out("pre_rst", 1'b1, 2);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 0);
    chk("async_rst_pend", pend_vec, 32'h0);
    chk("async_rst_start", dut.start_ptr_q, 32'h1);
    tick();
    rst = 1'b0;
    tick();
    chk_out("first_sel", 1'b1, 0);

    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 32; k++)
        sb.push_back(k);
    iters = 0;
    for (int c = 0; c < 200 && sb.size() > 0; c++) begin
      g = '0;
      if (out_valid && out_ready) begin
        exp_i = sb.pop_front();
        chk($sformatf("fair%0d", c),
            32'(out_entry_idx), 32'(exp_i));
        cnt[out_entry_idx]++;
        g = out_entry_ptr;
      end
      iters++;
      tick();
      entry_done_vec = g;
    end
    entry_done_vec = '0;
    chk("fair_sb_empty", 32'(sb.size()), 32'h0);
    chk("fair_cycles", 32'(iters), 32'd64);
    for (int k = 0; k < 32; k++)
      chk($sformatf("fair_cnt%0d", k),
          32'(cnt[k]), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
